// File: rtl/fpalu_pkg.sv
// Shared types and constants for the floating-point ALU sequencer.
// Op encodings, sequencer states and canonical FP operand values.
package fpalu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    localparam int FP_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    localparam logic [FP_WIDTH-1:0] ONE  = 32'h3F80_0000;
    localparam logic [FP_WIDTH-1:0] TWO  = 32'h4000_0000;
    localparam logic [FP_WIDTH-1:0] MAXF = 32'h7F7F_FFFF;

endpackage

// File: rtl/fpalu_stat_counter.sv
// Statistics counter with synchronous clear.
// SATURATE selects wrap (0) or hold-at-all-ones (1).
module fpalu_stat_counter #(
    parameter int COUNT_W  = 16,
    parameter int SATURATE = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            if (SATURATE != 0 && (&count)) begin
                count <= count;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpalu_sequencer.sv
// Request/response sequencer in front of the floating-point ALU.
// Launches operands, waits a fixed settle time, returns the result.
module fpalu_sequencer
    import fpalu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic               req_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_overflow,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_result,
    output logic               resp_overflow,
    input  logic               clear_counts,
    output logic [COUNT_W-1:0] op_count,
    output logic [COUNT_W-1:0] ovf_count,
    output logic               busy
);

    localparam int CNT_W = $clog2(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             handshake;
    logic             ovf_inc;

    assign handshake = (state == RESP) && resp_valid && resp_ready;
    assign ovf_inc   = handshake && resp_overflow;

    // alu_* are only written on accept so the ALU never sees a mode change
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= 1'b0;
            resp_valid    <= 1'b0;
            resp_result   <= '0;
            resp_overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_a     <= req_a;
                        alu_b     <= req_b;
                        alu_op    <= req_op;
                        wait_cnt  <= CNT_LOAD;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        resp_result   <= alu_result;
                        resp_overflow <= alu_overflow;
                        resp_valid    <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    fpalu_stat_counter #(
        .COUNT_W (COUNT_W),
        .SATURATE(0)
    ) u_op_count (
        .clock(clock),
        .reset(reset),
        .inc  (handshake),
        .clr  (clear_counts),
        .count(op_count)
    );

    fpalu_stat_counter #(
        .COUNT_W (COUNT_W),
        .SATURATE(1)
    ) u_ovf_count (
        .clock(clock),
        .reset(reset),
        .inc  (ovf_inc),
        .clr  (clear_counts),
        .count(ovf_count)
    );

endmodule
